// File: rtl/keypad_scan_port_if.sv
// CPU I/O bus slice seen by the keypad: select, direction, offset, write data and the OR-able read data.
interface keypad_scan_port_if;
  logic        cs;
  logic        isW;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, isW, addr, wdata, input rdata);
  modport slave  (input cs, isW, addr, wdata, output rdata);
endinterface

// File: rtl/keypad_scan_port.sv
// 4x4 keypad scanner with debounce; latches one code per press into VALUE/STATUS registers on the I/O bus.
// rdata is combinational and zero unless selected for read, so it can be OR-combined with other devices.
module keypad_scan_port #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 200000
) (
  input  logic               clk,
  input  logic               isReset,
  keypad_scan_port_if.slave  bus,
  input  logic [3:0]         row,
  output logic [3:0]         col
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state;
  logic [3:0]    rs_meta, rs, pat, value;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic          valid, overrun;
  logic [1:0]    row_idx, col_idx;
  logic          rd_clr, w1c_v, w1c_o, clr_v, latch;
  logic          unused_wdata;

  assign unused_wdata = ^bus.wdata[15:2];

  assign rd_clr = bus.cs && !bus.isW && (bus.addr == 4'h0);
  assign w1c_v  = bus.cs && bus.isW && (bus.addr == 4'h2) && bus.wdata[0];
  assign w1c_o  = bus.cs && bus.isW && (bus.addr == 4'h2) && bus.wdata[1];
  assign clr_v  = rd_clr || w1c_v;
  assign latch  = (state == DEBOUNCE) && (rs == pat) && (cnt == DEB_LAST);

  // Descending scan so the lowest-index low row is the last assignment and wins.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) row_idx = 2'(i);
      if (!col[i]) col_idx = 2'(i);
    end
  end

  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.cs && !bus.isW) begin
      if (bus.addr == 4'h0)      bus.rdata = {12'h000, value};
      else if (bus.addr == 4'h2) bus.rdata = {14'h0000, overrun, valid};
    end
  end

  always_ff @(posedge clk) begin
    if (!isReset) begin
      state   <= SCAN;
      col     <= 4'b1110;
      rs_meta <= 4'hF;
      rs      <= 4'hF;
      pat     <= 4'hF;
      div     <= '0;
      cnt     <= '0;
      value   <= 4'h0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;

      // A latch coinciding with a CPU clear keeps valid set and leaves overrun alone.
      if (latch) begin
        value <= {row_idx, col_idx};
        valid <= 1'b1;
        if (!clr_v) overrun <= (overrun && !w1c_o) || valid;
      end else begin
        if (clr_v) valid   <= 1'b0;
        if (w1c_o) overrun <= 1'b0;
      end

      case (state)
        SCAN: begin
          if (rs != 4'hF) begin
            state <= DEBOUNCE;
            pat   <= rs;
            cnt   <= '0;
            div   <= '0;
          end else if (div == DIV_LAST) begin
            div <= '0;
            col <= {col[2:0], col[3]};
          end else begin
            div <= div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rs != pat)            state <= SCAN;
          else if (cnt == DEB_LAST) state <= PRESSED;
          else                      cnt   <= cnt + 1'b1;
        end
        PRESSED: begin
          if (rs == 4'hF) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (rs != 4'hF)           state <= PRESSED;
          else if (cnt == DEB_LAST) state <= SCAN;
          else                      cnt   <= cnt + 1'b1;
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan_port.sv
// Bench for keypad_scan_port: directed corner sequences, a bus-op vector table, and random presses vs an event-level model.
module tb_keypad_scan_port;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       isReset = 1'b0;
  logic [3:0] row, col;
  keypad_scan_port_if bus();

  // Keypad matrix: a pressed key pulls its row low only while its column is driven.
  logic       key_on = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'hF;

  always_comb begin
    row = 4'hF;
    if (force_en) row = force_val;
    else if (key_on && (col[key_c] == 1'b0)) row = ~(4'b0001 << key_r);
  end

  keypad_scan_port #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .isReset(isReset), .bus(bus), .row(row), .col(col)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Event-level register model: one latch per completed press, bus ops applied between presses.
  logic       m_valid = 1'b0, m_over = 1'b0;
  logic [3:0] m_value = 4'h0;

  typedef struct {
    logic        cs;
    logic        isW;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_op(input logic c, input logic w, input logic [3:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input string name);
    @(negedge clk);
    bus.cs = c; bus.isW = w; bus.addr = a; bus.wdata = d;
    #1 check(name, bus.rdata, exp);
    @(posedge clk);
    #1 bus.cs = 1'b0; bus.isW = 1'b0; bus.addr = 4'h0; bus.wdata = 16'h0;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold, input int idle);
    @(negedge clk);
    key_r = r; key_c = c; key_on = 1'b1;
    tick(hold);
    @(negedge clk);
    key_on = 1'b0;
    tick(idle);
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'h0) return {12'h000, m_value};
    if (a == 4'h2) return {14'h0000, m_over, m_valid};
    return 16'h0000;
  endfunction

  // An unselected device must never drive the shared read bus.
  always @(posedge clk) begin
    if (bus.cs === 1'b0) begin
      vectors++;
      if (bus.rdata !== 16'h0000) begin
        miscompares++;
        $display("FAIL rdata_idle: got %h expected 0000", bus.rdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c0;
    bit found;
    bus.cs = 1'b0; bus.isW = 1'b0; bus.addr = 4'h0; bus.wdata = 16'h0;

    tbl[0]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h0003};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 16'hFFFF, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h0003};
    tbl[6]  = '{1'b1, 1'b1, 4'h2, 16'h0001, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h0002};
    tbl[8]  = '{1'b1, 1'b1, 4'h2, 16'h0003, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 16'h0000, 16'h000F};
    tbl[11] = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h0000};

    // Power-up reset and column stepping.
    tick(3);
    @(negedge clk) isReset = 1'b1;
    #1 check("reset_col", {12'h0, col}, 16'h000E);
    tick(3);
    @(negedge clk) check("col_hold_3", {12'h0, col}, 16'h000E);
    @(posedge clk); #1 check("col_step_4", {12'h0, col}, 16'h000D);
    bus_op(1, 0, 4'h2, 0, 16'h0000, "reset_status");
    bus_op(1, 0, 4'h0, 0, 16'h0000, "reset_value");

    // Key row1/col2 gives code 6; column freezes while held.
    @(negedge clk) begin key_r = 2'd1; key_c = 2'd2; key_on = 1'b1; end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1011) found = 1'b1;
    end
    check("wait_col_1011", {15'h0, found}, 16'h0001);
    tick(14);
    @(negedge clk) check("col_frozen", {12'h0, col}, 16'h000B);
    bus_op(1, 0, 4'h2, 0, 16'h0001, "press6_status");
    bus_op(1, 0, 4'h0, 0, 16'h0006, "press6_value");
    bus_op(1, 0, 4'h2, 0, 16'h0000, "press6_cleared");
    tick(50);
    bus_op(1, 0, 4'h2, 0, 16'h0000, "held_no_relatch");
    @(negedge clk) key_on = 1'b0;
    tick(25);

    // Short glitch is rejected and scanning resumes.
    @(negedge clk) begin force_val = 4'b1101; force_en = 1'b1; end
    tick(3);
    @(negedge clk) force_en = 1'b0;
    tick(20);
    bus_op(1, 0, 4'h2, 0, 16'h0000, "glitch_status");
    @(negedge clk) c0 = col;
    tick(5);
    @(negedge clk) check("glitch_scan_resumes", {15'h0, col != c0}, 16'h0001);

    // Two presses without a read: overrun, then table of bus ops.
    press(2'd0, 2'd0, 60, 25);
    press(2'd3, 2'd3, 60, 25);
    for (int i = 0; i < 12; i++)
      bus_op(tbl[i].cs, tbl[i].isW, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("tbl%0d", i));

    // Random presses and bus ops against the event-level model.
    m_valid = 1'b0; m_over = 1'b0; m_value = 4'hF;
    for (int it = 0; it < 16; it++) begin
      int nops;
      logic [1:0] r, c;
      nops = $urandom_range(0, 3);
      for (int k = 0; k < nops; k++) begin
        int kind;
        logic [3:0]  a;
        logic [15:0] d;
        kind = $urandom_range(0, 3);
        a = 4'($urandom_range(0, 15));
        d = 16'($urandom);
        case (kind)
          0: begin
            bus_op(1, 0, a, 0, m_read(a), "rnd_read");
            if (a == 4'h0) m_valid = 1'b0;
          end
          1: begin
            bus_op(1, 1, 4'h2, d, 16'h0000, "rnd_w1c");
            if (d[0]) m_valid = 1'b0;
            if (d[1]) m_over = 1'b0;
          end
          2: begin
            bus_op(1, 1, a, d, 16'h0000, "rnd_write");
            if (a == 4'h2 && d[0]) m_valid = 1'b0;
            if (a == 4'h2 && d[1]) m_over = 1'b0;
          end
          default: bus_op(1, 0, 4'h2, 0, m_read(4'h2), "rnd_status");
        endcase
      end
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      press(r, c, 60, 25);
      if (m_valid) m_over = 1'b1;
      m_valid = 1'b1;
      m_value = {r, c};
      bus_op(1, 0, 4'h2, 0, m_read(4'h2), "rnd_post_status");
    end
    bus_op(1, 0, 4'h2, 0, m_read(4'h2), "rnd_final_status");

    // Reset during DEBOUNCE of a key on column 1; key is re-debounced afterwards.
    @(negedge clk) begin key_r = 2'd0; key_c = 2'd1; key_on = 1'b1; isReset = 1'b0; end
    @(posedge clk);
    @(negedge clk) isReset = 1'b1;
    tick(9);
    @(negedge clk);
    #1 check("debounce_col_frozen", {12'h0, col}, 16'h000D);
    isReset = 1'b0;
    @(posedge clk);
    #1 check("midreset_col", {12'h0, col}, 16'h000E);
    bus.cs = 1'b1; bus.isW = 1'b0; bus.addr = 4'h2;
    #1 check("midreset_status", bus.rdata, 16'h0000);
    bus.cs = 1'b0;
    @(negedge clk) isReset = 1'b1;
    tick(40);
    bus_op(1, 0, 4'h2, 0, 16'h0001, "after_reset_status");
    bus_op(1, 0, 4'h0, 0, 16'h0001, "after_reset_value");
    @(negedge clk) key_on = 1'b0;
    tick(25);

    // Clear (read, then W1C) landing on the exact latch edge: latch wins, no overrun.
    for (int v = 0; v < 2; v++) begin
      @(negedge clk) begin key_r = 2'd1; key_c = 2'd0; key_on = 1'b1; isReset = 1'b0; end
      @(posedge clk);
      @(negedge clk) isReset = 1'b1;
      tick(10);
      @(negedge clk);
      bus.cs = 1'b1; bus.isW = (v == 1); bus.addr = (v == 1) ? 4'h2 : 4'h0; bus.wdata = 16'h0003;
      #1 check("collide_rdata", bus.rdata, 16'h0000);
      @(posedge clk);
      #1 bus.cs = 1'b0; bus.isW = 1'b0; bus.addr = 4'h0; bus.wdata = 16'h0;
      bus_op(1, 0, 4'h2, 0, 16'h0001, v == 1 ? "collide_w1c_status" : "collide_rd_status");
      bus_op(1, 0, 4'h0, 0, 16'h0004, "collide_value");
      @(negedge clk) key_on = 1'b0;
      tick(25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
